// File: rtl/sweep_ctrl.sv
// sweep_ctrl: sequences an external up/down counter from lo to hi
// (single sweep or ping-pong round trips), with stop abort and bound check.
// Ports: clk, rst (async, active-high); start/stop requests; lo/hi bounds,
//   pingpong, sweeps, pre_div (latched on accept); count_in from counter;
//   cnt_load/cnt_enable/cnt_up_down/cnt_data counter controls;
//   ready/busy/done phase flags; status (00 ok, 01 aborted, 10 bound error).
// Config: define SWEEP_CTRL_PRESCALE_EN to gate counting with a prescaler.
module sweep_ctrl #(
    parameter int WIDTH     = 4,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     lo,
    input  logic [WIDTH-1:0]     hi,
    input  logic                 pingpong,
    input  logic [7:0]           sweeps,
    input  logic [PRE_WIDTH-1:0] pre_div,
    input  logic [WIDTH-1:0]     count_in,
    output logic                 cnt_load,
    output logic                 cnt_enable,
    output logic                 cnt_up_down,
    output logic [WIDTH-1:0]     cnt_data,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             pp_q;
    logic [7:0]       left_q;
    logic [7:0]       left_n;
    logic [1:0]       status_q;
    logic [1:0]       status_n;
    logic             accept;
    logic             tick;

    assign accept = (state == IDLE) && start && !stop;

`ifdef SWEEP_CTRL_PRESCALE_EN
    logic [PRE_WIDTH-1:0] pre_q;
    logic [PRE_WIDTH-1:0] pre_cnt;

    // Prescaler restarts on every state change so each UP/DOWN entry
    // waits a full pre_div+1 cycles before its first tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            pre_cnt <= '0;
        end else begin
            if (accept)
                pre_q <= pre_div;
            if (state_n != state)
                pre_cnt <= '0;
            else if (state == UP || state == DOWN)
                pre_cnt <= (pre_cnt == pre_q) ? '0 : pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == pre_q);
`else
    logic unused_pre;

    assign unused_pre = ^pre_div;
    assign tick       = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            pp_q     <= 1'b0;
            left_q   <= '0;
            status_q <= 2'b00;
        end else begin
            state    <= state_n;
            left_q   <= left_n;
            status_q <= status_n;
            if (accept) begin
                lo_q <= lo;
                hi_q <= hi;
                pp_q <= pingpong;
            end
        end
    end

    always_comb begin
        state_n     = state;
        left_n      = left_q;
        status_n    = status_q;
        cnt_load    = 1'b0;
        cnt_enable  = 1'b0;
        cnt_up_down = 1'b0;
        cnt_data    = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = LOAD;
                    status_n = 2'b00;
                    // A zero round-trip count still runs one trip.
                    left_n   = (sweeps == 8'd0) ? 8'd1 : sweeps;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                cnt_data = lo_q;
                if (stop) begin
                    state_n  = DONE;
                    status_n = 2'b01;
                end else if (lo_q >= hi_q) begin
                    state_n  = DONE;
                    status_n = 2'b10;
                end else begin
                    state_n = UP;
                end
            end
            UP: begin
                cnt_up_down = 1'b1;
                if (stop) begin
                    state_n  = DONE;
                    status_n = 2'b01;
                end else if (count_in == hi_q) begin
                    if (pp_q) begin
                        state_n = DOWN;
                    end else begin
                        state_n  = DONE;
                        status_n = 2'b00;
                    end
                end else begin
                    cnt_enable = tick;
                end
            end
            DOWN: begin
                if (stop) begin
                    state_n  = DONE;
                    status_n = 2'b01;
                end else if (count_in == lo_q) begin
                    left_n = left_q - 8'd1;
                    if (left_q == 8'd1) begin
                        state_n  = DONE;
                        status_n = 2'b00;
                    end else begin
                        state_n = UP;
                    end
                end else begin
                    cnt_enable = tick;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ready  = (state == IDLE);
    assign busy   = (state == LOAD) || (state == UP) || (state == DOWN);
    assign done   = (state == DONE);
    assign status = done ? status_q : 2'b00;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed self-checking bench for sweep_ctrl
// with a behavioural up/down counter closing the loop.
module tb_sweep_ctrl;

    localparam int W  = 4;
    localparam int PW = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          stop     = 1'b0;
    logic          pingpong = 1'b0;
    logic [W-1:0]  lo       = '0;
    logic [W-1:0]  hi       = '0;
    logic [7:0]    sweeps   = '0;
    logic [PW-1:0] pre_div  = '0;
    logic [W-1:0]  count_in;
    logic          cnt_load;
    logic          cnt_enable;
    logic          cnt_up_down;
    logic [W-1:0]  cnt_data;
    logic          ready;
    logic          busy;
    logic          done;
    logic [1:0]    status;

    logic [W-1:0]  cnt_model = '0;

    int n_tests = 0;
    int n_fail  = 0;

    sweep_ctrl #(.WIDTH(W), .PRE_WIDTH(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .lo          (lo),
        .hi          (hi),
        .pingpong    (pingpong),
        .sweeps      (sweeps),
        .pre_div     (pre_div),
        .count_in    (count_in),
        .cnt_load    (cnt_load),
        .cnt_enable  (cnt_enable),
        .cnt_up_down (cnt_up_down),
        .cnt_data    (cnt_data),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .status      (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_load)
            cnt_model <= cnt_data;
        else if (cnt_enable)
            cnt_model <= cnt_up_down ? cnt_model + 1'b1
                                     : cnt_model - 1'b1;
    end

    assign count_in = cnt_model;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one sweep; k counts falling edges after the start edge
    // (k=1 is the LOAD cycle).
    task automatic run_sweep(input  logic [3:0]  l,
                             input  logic [3:0]  h,
                             input  logic        p,
                             input  logic [7:0]  s,
                             input  logic [7:0]  pd,
                             output int          ens,
                             output int          lat,
                             output int          dones,
                             output int          first_en,
                             output int          viol,
                             output logic [1:0]  st,
                             output logic [63:0] trace);
        logic       have;
        logic [3:0] last;
        logic       fin;
        ens      = 0;
        lat      = 0;
        dones    = 0;
        first_en = 0;
        viol     = 0;
        st       = 2'b11;
        trace    = '0;
        have     = 1'b0;
        last     = '0;
        fin      = 1'b0;
        @(negedge clk);
        lo       = l;
        hi       = h;
        pingpong = p;
        sweeps   = s;
        pre_div  = pd;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 300 && !fin; k++) begin
            if (cnt_enable) begin
                ens++;
                if (first_en == 0) first_en = k;
            end
            if (cnt_load && cnt_enable) viol++;
            if (cnt_enable &&
                ((cnt_up_down && count_in == h) ||
                 (!cnt_up_down && count_in == l)))
                viol++;
            if (busy && !cnt_load && (!have || count_in != last)) begin
                trace = {trace[59:0], count_in};
                last  = count_in;
                have  = 1'b1;
            end
            if (done) begin
                dones++;
                st  = status;
                lat = k;
                fin = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    initial begin
        int          ens, lat, dones, fe, viol;
        logic [1:0]  st;
        logic [63:0] tr;
        logic        found;
        int          dseen;

        #12;
        check("reset_flags",
              {ready, busy, done, cnt_load, cnt_enable, cnt_up_down, status},
              8'b1000_0000);
        check("reset_data", cnt_data, 0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        check("start_with_stop", {ready, busy}, 2'b10);
        start = 1'b0;
        stop  = 1'b0;

        run_sweep(4'd2, 4'd5, 1'b0, 8'd0, 8'd0, ens, lat, dones, fe, viol, st, tr);
        check("single_ens", ens, 3);
        check("single_trace", tr, 64'h2345);
        check("single_status", st, 2'b00);
        check("single_lat", lat, 6);
        check("single_dones", dones, 1);
        check("single_viol", viol, 0);
        check("single_ready", ready, 1);

        run_sweep(4'd1, 4'd3, 1'b1, 8'd2, 8'd0, ens, lat, dones, fe, viol, st, tr);
        check("pp2_ens", ens, 8);
        check("pp2_trace", tr, 64'h123212321);
        check("pp2_status", st, 2'b00);
        check("pp2_lat", lat, 14);
        check("pp2_dones", dones, 1);
        check("pp2_viol", viol, 0);

        run_sweep(4'd1, 4'd3, 1'b1, 8'd0, 8'd0, ens, lat, dones, fe, viol, st, tr);
        check("pp0_ens", ens, 4);
        check("pp0_trace", tr, 64'h12321);
        check("pp0_lat", lat, 8);

        run_sweep(4'd7, 4'd7, 1'b0, 8'd0, 8'd0, ens, lat, dones, fe, viol, st, tr);
        check("eq_ens", ens, 0);
        check("eq_status", st, 2'b10);
        check("eq_lat", lat, 2);
        check("eq_dones", dones, 1);

        run_sweep(4'd5, 4'd3, 1'b1, 8'd1, 8'd0, ens, lat, dones, fe, viol, st, tr);
        check("inv_ens", ens, 0);
        check("inv_status", st, 2'b10);

`ifdef SWEEP_CTRL_PRESCALE_EN
        run_sweep(4'd0, 4'd2, 1'b0, 8'd0, 8'd3, ens, lat, dones, fe, viol, st, tr);
        check("pre_ens", ens, 2);
        check("pre_first", fe, 5);
        check("pre_lat", lat, 11);
        check("pre_trace", tr, 64'h012);
        check("pre_status", st, 2'b00);
`else
        run_sweep(4'd0, 4'd2, 1'b0, 8'd0, 8'd3, ens, lat, dones, fe, viol, st, tr);
        check("nopre_ens", ens, 2);
        check("nopre_first", fe, 2);
        check("nopre_lat", lat, 5);
        check("nopre_trace", tr, 64'h012);
`endif

        @(negedge clk);
        lo       = 4'd0;
        hi       = 4'd7;
        pingpong = 1'b0;
        pre_div  = 8'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (busy && !cnt_load && count_in == 4'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("stop_reach", found, 1);
        stop = 1'b1;
        #1;
        check("stop_enable", cnt_enable, 0);
        @(negedge clk);
        check("stop_done", {done, status}, 3'b101);
        check("stop_hold", count_in, 4'd3);
        stop = 1'b0;
        @(negedge clk);
        check("stop_ready", {ready, busy, done}, 3'b100);

        @(negedge clk);
        lo       = 4'd1;
        hi       = 4'd3;
        pingpong = 1'b1;
        sweeps   = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (busy && !cnt_load && !cnt_up_down) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_reach_down", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_flags",
              {ready, busy, done, cnt_load, cnt_enable, cnt_up_down, status},
              8'b1000_0000);
        check("rst_data", cnt_data, 0);
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dseen++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("rst_no_done", dseen, 0);

        run_sweep(4'd2, 4'd5, 1'b0, 8'd0, 8'd0, ens, lat, dones, fe, viol, st, tr);
        check("post_rst_ens", ens, 3);
        check("post_rst_status", st, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, width of the counter being sequenced and of lo/hi/cnt_data/count_in.
REQ-002 Parameter PRE_WIDTH, default 8, width of the prescaler divide value (used only with SWEEP_CTRL_PRESCALE_EN).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  sweep request; accepted only when ready=1.
REQ-006 stop  input  1  abort request; level-sampled each cycle.
REQ-007 lo  input  WIDTH  sweep lower bound; latched on start acceptance.
REQ-008 hi  input  WIDTH  sweep upper bound; latched on start acceptance.
REQ-009 pingpong  input  1  0 = single up sweep, 1 = up/down round trips; latched on acceptance.
REQ-010 sweeps  input  8  round-trip count for pingpong mode; latched on acceptance.
REQ-011 pre_div  input  PRE_WIDTH  tick divider; latched on acceptance.
REQ-012 count_in  input  WIDTH  current value from the sequenced counter.
REQ-013 cnt_load, cnt_enable, cnt_up_down  output  1 each  counter control strobes.
REQ-014 cnt_data  output  WIDTH  counter load value.
REQ-015 ready  output  1  high in IDLE only.
REQ-016 busy  output  1  high in LOAD, UP, DOWN.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 status  output  2  valid with done: 00 ok, 01 aborted, 10 bound error.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, UP, DOWN, DONE.
REQ-020 IDLE: start=1 and stop=0 at edge T SHALL latch inputs and enter LOAD at T+1; start with stop=1 SHALL be ignored.
REQ-021 If latched lo>=hi, the FSM SHALL go LOAD->DONE with status=10 and SHALL NOT assert cnt_enable.
REQ-022 LOAD: cnt_load=1, cnt_data=lo for exactly one cycle, then UP.
REQ-023 UP: cnt_up_down=1; cnt_enable=tick AND count_in!=hi; on count_in==hi, single mode -> DONE, pingpong -> DOWN.
REQ-024 DOWN: cnt_up_down=0; cnt_enable=tick AND count_in!=lo; on count_in==lo, decrement remaining sweeps; remaining reaching 0 -> DONE, else -> UP.
REQ-025 pingpong with sweeps=0 SHALL be treated as sweeps=1.
REQ-026 cnt_enable SHALL never be asserted at a bound, so the counter never wraps past lo or hi.
REQ-027 stop=1 in LOAD/UP/DOWN SHALL deassert cnt_enable in that same cycle and enter DONE with status=01 on the next edge.
REQ-028 DONE: done=1 for one cycle, status held, then IDLE; cnt_load=cnt_enable=0.
REQ-029 cnt_load and cnt_enable SHALL never be high simultaneously.
REQ-030 ready/busy/done SHALL be mutually exclusive with IDLE/active/DONE respectively.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, all outputs 0 except ready=1, sweep and prescaler counters 0.
REQ-032 Reset mid-sweep SHALL produce no done pulse.

Configuration
REQ-033 Macro SWEEP_CTRL_PRESCALE_EN defined: tick=1 once every pre_div+1 cycles in UP/DOWN, prescaler restarts on each UP/DOWN entry, first tick pre_div+1 cycles after entry.
REQ-034 Macro undefined: tick=1 every cycle, pre_div ignored, no prescaler register.

Verification
REQ-035 lo=2, hi=5, pingpong=0, no prescale: load 2, enables 3 cycles, done with status=00 at count_in=5.
REQ-036 lo=1, hi=3, pingpong=1, sweeps=2: count 1-2-3-2-1-2-3-2-1, single done pulse, status=00.
REQ-037 lo=7, hi=7: no enable, done with status=10 two cycles after start.
REQ-038 stop asserted during UP at count_in=3: cnt_enable low same cycle, done with status=01 next edge, then ready=1.
REQ-039 rst asserted in DOWN: outputs cleared asynchronously, ready=1, no done pulse.
REQ-040 PRESCALE_EN, pre_div=3, lo=0, hi=2: enables exactly every 4th cycle, done after count_in=2.
